// File: rtl/fun_iter.sv
// Purpose : y = isqrt(a + icbrt(b)) on unsigned WIDTH-bit operands, bit-serial cube/square root engines.
// Latency : CB cube-root steps plus SB square-root steps after the start edge; valid_o in the first IDLE cycle.
// Backpressure: none; start_i is sampled only while idle, and busy_o=1 marks the engine as occupied.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous reset, active-low
//   start_i  request, sampled only while busy_o=0
//   a_bi     operand a (unsigned, WIDTH bits)
//   b_bi     operand b (unsigned, WIDTH bits)
//   busy_o   high while a computation is in progress
//   valid_o  one-cycle pulse when y_bo carries a new result
//   y_bo     result, held until the next result or reset
module fun_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_bi,
    input  logic [WIDTH-1:0] b_bi,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] y_bo
);

    // Result widths of the two roots and the full-precision sum width.
    localparam int CB = (WIDTH + 2) / 3;
    localparam int SW = WIDTH + 1;
    localparam int SB = (SW + 1) / 2;
    // Compare widths: a CB-bit cube needs 3*CB bits, an SB-bit square 2*SB bits.
    localparam int CW = 3 * CB;
    localparam int QW = 2 * SB;
    // One shared bit-index counter; SB >= CB, so it is sized for the longer phase.
    localparam int IW = (SB > 1) ? $clog2(SB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CBRT = 2'd1,
        SQRT = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [WIDTH-1:0] a_q, a_nx;
    logic [WIDTH-1:0] b_q, b_nx;
    logic [CB-1:0]    c_q, c_nx;
    logic [SB-1:0]    r_q, r_nx;
    logic [SW-1:0]    s_q, s_nx;
    logic [IW-1:0]    idx_q, idx_nx;
    logic [WIDTH-1:0] y_q, y_nx;
    logic             valid_q, valid_nx;

    // Trial values for the current bit position.
    logic [CB-1:0] c_trial;
    logic [CW-1:0] c_ext;
    logic [CW-1:0] c_cube;
    logic          c_take;
    logic [CB-1:0] c_step;
    logic [SB-1:0] r_trial;
    logic [QW-1:0] r_ext;
    logic [QW-1:0] r_square;
    logic          r_take;
    logic [SB-1:0] r_step;

    always_comb begin
        c_trial  = c_q | (CB'(1) << idx_q);
        c_ext    = CW'(c_trial);
        c_cube   = c_ext * c_ext * c_ext;
        c_take   = (c_cube <= CW'(b_q));
        c_step   = c_take ? c_trial : c_q;

        r_trial  = r_q | (SB'(1) << idx_q);
        r_ext    = QW'(r_trial);
        r_square = r_ext * r_ext;
        // Wide compare: the sum is at most SW bits and QW >= SW.
        r_take   = (r_square <= QW'(s_q));
        r_step   = r_take ? r_trial : r_q;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        c_nx     = c_q;
        r_nx     = r_q;
        s_nx     = s_q;
        idx_nx   = idx_q;
        y_nx     = y_q;
        valid_nx = 1'b0;

        unique case (state)
            IDLE: begin
                if (start_i) begin
                    a_nx     = a_bi;
                    b_nx     = b_bi;
                    c_nx     = '0;
                    r_nx     = '0;
                    idx_nx   = IW'(CB - 1);
                    state_nx = CBRT;
                end
            end
            CBRT: begin
                c_nx = c_step;
                if (idx_q == '0) begin
                    // Sum uses the just-resolved cube root, one bit wider than a: no wrap.
                    s_nx     = {1'b0, a_q} + SW'(c_step);
                    idx_nx   = IW'(SB - 1);
                    state_nx = SQRT;
                end else begin
                    idx_nx = idx_q - IW'(1);
                end
            end
            SQRT: begin
                r_nx = r_step;
                if (idx_q == '0) begin
                    y_nx     = WIDTH'(r_step);
                    valid_nx = 1'b1;
                    state_nx = IDLE;
                end else begin
                    idx_nx = idx_q - IW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            a_q     <= a_nx;
            b_q     <= b_nx;
            c_q     <= c_nx;
            r_q     <= r_nx;
            s_q     <= s_nx;
            idx_q   <= idx_nx;
            y_q     <= y_nx;
            valid_q <= valid_nx;
        end
    end

    assign busy_o  = (state != IDLE);
    assign valid_o = valid_q;
    assign y_bo    = y_q;

endmodule

// File: tb/tb_fun_iter.sv
// Purpose : directed self-checking bench for fun_iter at WIDTH=8 and WIDTH=16.
// Latency : counts clock edges from the start edge up to the valid_o pulse.
// Backpressure: exercises ignored starts while busy and back-to-back starts.
module tb_fun_iter;

    logic        clk;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, valid8, busy16, valid16;
    logic [7:0]  y8;
    logic [15:0] y16;

    int n_checks = 0;
    int n_errors = 0;

    fun_iter #(.WIDTH(8)) dut8 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start8),
        .a_bi    (a8),
        .b_bi    (b8),
        .busy_o  (busy8),
        .valid_o (valid8),
        .y_bo    (y8)
    );

    fun_iter #(.WIDTH(16)) dut16 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start16),
        .a_bi    (a16),
        .b_bi    (b16),
        .busy_o  (busy16),
        .valid_o (valid16),
        .y_bo    (y16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts edges until valid_o is seen (sampled 1 time unit after each edge).
    // Optionally drops start after the first edge. Bounded at 40 edges.
    task automatic wait_valid(input bit wide, input bit drop_start, output int lat);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (drop_start) begin
                if (wide) start16 = 1'b0;
                else      start8  = 1'b0;
            end
            if (wide ? valid16 : valid8) break;
        end
    endtask

    task automatic run8(input string tag, input int a, input int b, input int exp_y);
        int lat;
        a8     = 8'(a);
        b8     = 8'(b);
        start8 = 1'b1;
        wait_valid(1'b0, 1'b1, lat);
        check({tag, "_lat"}, lat, 9);
        check({tag, "_y"}, int'(y8), exp_y);
        @(posedge clk);
        #1;
        check({tag, "_pulse_len"}, int'(valid8), 0);
    endtask

    initial begin
        int lat;
        int pulses;

        rst     = 1'b0;
        start8  = 1'b0;
        start16 = 1'b0;
        a8      = '0;
        b8      = '0;
        a16     = '0;
        b16     = '0;

        // Reset state
        #2;
        check("rst_busy8", int'(busy8), 0);
        check("rst_valid8", int'(valid8), 0);
        check("rst_y8", int'(y8), 0);
        check("rst_busy16", int'(busy16), 0);
        check("rst_y16", int'(y16), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic results
        run8("zero", 0, 0, 0);
        run8("a10_b27", 10, 27, 3);
        run8("a14_b8", 14, 8, 4);
        run8("max8", 255, 255, 16);

        // Start while busy is ignored, operand changes have no effect
        a8     = 8'd10;
        b8     = 8'd27;
        start8 = 1'b1;
        lat    = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                start8 = 1'b0;
                check("busy_after_start", int'(busy8), 1);
            end
            if (lat == 3) begin
                start8 = 1'b1;
                a8     = 8'd14;
                b8     = 8'd8;
            end
            if (lat == 4) start8 = 1'b0;
            if (valid8) break;
        end
        check("ign_lat", lat, 9);
        check("ign_y", int'(y8), 3);
        check("ign_idle_at_valid", int'(busy8), 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (valid8) pulses++;
        end
        check("ign_extra_pulses", pulses, 0);

        // Back-to-back: start held high through the valid cycle
        a8     = 8'd10;
        b8     = 8'd27;
        start8 = 1'b1;
        wait_valid(1'b0, 1'b0, lat);
        check("b2b_first_lat", lat, 9);
        check("b2b_first_y", int'(y8), 3);
        a8 = 8'd14;
        b8 = 8'd8;
        wait_valid(1'b0, 1'b0, lat);
        start8 = 1'b0;
        check("b2b_second_lat", lat, 9);
        check("b2b_second_y", int'(y8), 4);
        @(posedge clk);
        #1;
        check("b2b_idle_after", int'(busy8), 0);

        // Reset mid-CBRT aborts, no pulse follows
        a8     = 8'd255;
        b8     = 8'd255;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_busy", int'(busy8), 0);
        check("abort_valid", int'(valid8), 0);
        check("abort_y", int'(y8), 0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (valid8) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        check("abort_y_held", int'(y8), 0);

        // WIDTH=16 extreme operands
        a16     = 16'hFFFF;
        b16     = 16'hFFFF;
        start16 = 1'b1;
        wait_valid(1'b1, 1'b1, lat);
        check("w16_lat", lat, 16);
        check("w16_y", int'(y16), 256);
        @(posedge clk);
        #1;
        check("w16_pulse_len", int'(valid16), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
